// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 receiver: FSM encoding, frame layout
// and the frame-acceptance check.
package ps2_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    RECV = 1'b1
  } state_t;

  localparam int FRAME_BITS = 11;
  localparam int STOP_IDX   = 10;
  localparam int PARITY_IDX = 9;

  // Frame is good when data plus parity holds an odd number of ones
  // and the stop bit is high.
  function automatic logic frame_ok(input logic [8:0] data_par, input logic stop);
    return (^data_par) & stop;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Brings the asynchronous PS/2 pins into the clk domain and flags the
// falling edge of the synchronized PS/2 clock. All flops reset to the
// idle bus level (1) so reset never fabricates an edge.
module ps2_sync_edge
  import ps2_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic ps2_clk,
  input  logic ps2_data,
  output logic sync_data,
  output logic fall
);

  logic clk_meta_r;
  logic clk_sync_r;
  logic clk_prev_r;
  logic data_meta_r;
  logic data_sync_r;

  // Two-flop synchronizers on both pins plus one history flop on the clock line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      clk_prev_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      clk_prev_r  <= clk_sync_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
    end
  end

  // One-cycle strobe: synced clock was high last cycle and is low now.
  assign fall      = clk_prev_r & ~clk_sync_r;
  assign sync_data = data_sync_r;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host receiver. Deframes start/8 data/odd parity/stop,
// pulses code_valid on a good frame and frame_err on a bad or stalled
// one. The last good code is held, split into nibbles for the display.
module ps2_rx
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [3:0] nib_hi,
  output logic [3:0] nib_lo,
  output logic       busy
);

  // Counter runs 0..TIMEOUT_CYCLES-2; the step that would reach
  // TIMEOUT_CYCLES-1 is where the frame is abandoned instead.
  localparam int                TMO_W    = $clog2(TIMEOUT_CYCLES);
  localparam logic [TMO_W-1:0]  TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 2);
  localparam logic [3:0]        BIT_STOP = 4'(STOP_IDX);

  state_t           state_r;
  logic [3:0]       bit_cnt_r;
  logic [8:0]       shift_r;    // {parity, data[7:0]} once all nine bits are in
  logic [TMO_W-1:0] tmo_r;
  logic             sync_data_s;
  logic             fall_s;

  ps2_sync_edge u_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .sync_data (sync_data_s),
    .fall      (fall_s)
  );

  // Frame FSM with registered pulses, held code/nibbles and busy flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      bit_cnt_r  <= 4'd0;
      shift_r    <= 9'd0;
      tmo_r      <= '0;
      code       <= 8'd0;
      nib_hi     <= 4'd0;
      nib_lo     <= 4'd0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state_r)
        IDLE: begin
          tmo_r <= '0;
          // Only a low data bit on a falling edge is a start bit.
          if (fall_s && !sync_data_s) begin
            state_r   <= RECV;
            bit_cnt_r <= 4'd1;
            busy      <= 1'b1;
          end else begin
            state_r   <= IDLE;
          end
        end
        RECV: begin
          if (fall_s) begin
            tmo_r <= '0;
            if (bit_cnt_r == BIT_STOP) begin
              state_r   <= IDLE;
              bit_cnt_r <= 4'd0;
              busy      <= 1'b0;
              if (frame_ok(shift_r, sync_data_s)) begin
                code       <= shift_r[7:0];
                nib_hi     <= shift_r[7:4];
                nib_lo     <= shift_r[3:0];
                code_valid <= 1'b1;
              end else begin
                frame_err  <= 1'b1;
              end
            end else begin
              // LSB arrives first, so shifting right lands data[0] at bit 0.
              shift_r   <= {sync_data_s, shift_r[8:1]};
              bit_cnt_r <= bit_cnt_r + 4'd1;
            end
          end else if (tmo_r == TMO_LAST) begin
            state_r   <= IDLE;
            bit_cnt_r <= 4'd0;
            busy      <= 1'b0;
            tmo_r     <= '0;
            frame_err <= 1'b1;
          end else begin
            tmo_r <= tmo_r + TMO_W'(1);
          end
        end
        default: begin
          state_r   <= IDLE;
          bit_cnt_r <= 4'd0;
          tmo_r     <= '0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_rx.sv
// Directed plus randomized bench for ps2_rx. A PS/2 device is modelled
// bit by bit; expected codes come from odd-parity arithmetic on the data.
module tb_ps2_rx;

  localparam int HALF = 20;   // clk cycles per PS/2 clock half-period
  localparam int TMO  = 100;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] code;
  logic       code_valid;
  logic       frame_err;
  logic [3:0] nib_hi;
  logic [3:0] nib_lo;
  logic       busy;

  int   cyc = 0;
  int   cv_cnt = 0;
  int   fe_cnt = 0;
  int   cv_cyc = 0;
  int   fe_cyc = 0;
  logic both_seen = 1'b0;

  int         errors = 0;
  int         checks = 0;
  int         last_low = 0;
  logic [7:0] exp_code = 8'h00;

  ps2_rx #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .code       (code),
    .code_valid (code_valid),
    .frame_err  (frame_err),
    .nib_hi     (nib_hi),
    .nib_lo     (nib_lo),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  // Edge index: cyc equals k after the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (code_valid) begin
      cv_cnt <= cv_cnt + 1;
      cv_cyc <= cyc;
    end
    if (frame_err) begin
      fe_cnt <= fe_cnt + 1;
      fe_cyc <= cyc;
    end
    if (code_valid && frame_err) both_seen <= 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive the first n bits of an 11-bit frame (bit 0 = start).
  task automatic send_bits(input logic [10:0] fr, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ps2_data = fr[i];
      repeat (HALF) @(negedge clk);
      ps2_clk  = 1'b0;
      last_low = cyc;
      repeat (HALF) @(negedge clk);
      ps2_clk  = 1'b1;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_code"},   32'(code),   32'(exp_code));
    check({tag, "_nib_hi"}, 32'(nib_hi), 32'(exp_code[7:4]));
    check({tag, "_nib_lo"}, 32'(nib_lo), 32'(exp_code[3:0]));
    check({tag, "_busy"},   32'(busy),   32'd0);
  endtask

  // Full frame with model: good iff data+parity has odd weight and stop is 1.
  task automatic do_frame(input string tag, input logic [7:0] d, input logic p, input logic s);
    int   cv0;
    int   fe0;
    logic good;
    good = ((($countones(d) + int'(p)) % 2) == 1) && s;
    cv0  = cv_cnt;
    fe0  = fe_cnt;
    send_bits({s, p, d, 1'b0}, 11);
    repeat (10) @(negedge clk);
    if (good) exp_code = d;
    check({tag, "_valid_cnt"}, 32'(cv_cnt - cv0), good ? 32'd1 : 32'd0);
    check({tag, "_err_cnt"},   32'(fe_cnt - fe0), good ? 32'd0 : 32'd1);
    check({tag, "_latency"},   good ? 32'(cv_cyc) : 32'(fe_cyc), 32'(last_low + 3));
    check_outputs(tag);
  endtask

  initial begin
    int         cv0;
    int         fe0;
    logic [7:0] d;
    logic       perr;
    logic       serr;

    // Reset
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_valid", 32'(code_valid), 32'd0);
    check("rst_err",   32'(frame_err),  32'd0);
    check_outputs("rst");

    // Basic good frame
    do_frame("f1c", 8'h1C, 1'b0, 1'b1);

    // Back-to-back F0 then 1C
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_bits({1'b1, 1'b1, 8'hF0, 1'b0}, 11);
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 11);
    repeat (10) @(negedge clk);
    exp_code = 8'h1C;
    check("b2b_valid_cnt", 32'(cv_cnt - cv0), 32'd2);
    check("b2b_err_cnt",   32'(fe_cnt - fe0), 32'd0);
    check_outputs("b2b");

    // Error frames keep the previous code
    do_frame("f45",      8'h45, 1'b0, 1'b1);
    do_frame("bad_par",  8'h1C, 1'b1, 1'b1);
    do_frame("bad_stop", 8'h45, 1'b0, 1'b0);

    // Timeout after 5 bits
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    send_bits({1'b1, 1'b0, 8'h45, 1'b0}, 5);
    check("tmo_busy_mid", 32'(busy), 32'd1);
    repeat (120) @(negedge clk);
    check("tmo_err_cnt",   32'(fe_cnt - fe0), 32'd1);
    check("tmo_valid_cnt", 32'(cv_cnt - cv0), 32'd0);
    check("tmo_latency",   32'(fe_cyc), 32'(last_low + 3 + TMO - 1));
    check_outputs("tmo");
    do_frame("after_tmo", 8'h45, 1'b0, 1'b1);

    // Spurious falling edge with data high while idle
    cv0 = cv_cnt;
    fe0 = fe_cnt;
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clk);
    check("spur_valid_cnt", 32'(cv_cnt - cv0), 32'd0);
    check("spur_err_cnt",   32'(fe_cnt - fe0), 32'd0);
    check_outputs("spur");
    do_frame("after_spur", 8'h1C, 1'b0, 1'b1);

    // Reset for one cycle after bit 6
    fe0 = fe_cnt;
    cv0 = cv_cnt;
    send_bits({1'b1, 1'b0, 8'h1C, 1'b0}, 7);
    repeat (5) @(negedge clk);
    check("mid_busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_code = 8'h00;
    check("mid_valid", 32'(code_valid), 32'd0);
    check("mid_err",   32'(frame_err),  32'd0);
    check_outputs("mid_rst");
    repeat (150) @(negedge clk);
    check("mid_err_cnt",   32'(fe_cnt - fe0), 32'd0);
    check("mid_valid_cnt", 32'(cv_cnt - cv0), 32'd0);
    do_frame("after_rst", 8'h45, 1'b0, 1'b1);

    // Randomized frames with occasional parity/stop faults
    for (int k = 0; k < 8; k++) begin
      d    = 8'($urandom_range(0, 255));
      perr = ($urandom_range(0, 3) == 0);
      serr = ($urandom_range(0, 7) == 0);
      do_frame("rand", d, (~^d) ^ perr, ~serr);
    end

    check("exclusive", 32'(both_seen), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ps2_rx.md
Name: ps2_rx

Overview:
PS/2 device-to-host receiver. Oversamples the keyboard's ps2_clk/ps2_data lines in the system clock domain and deframes 11-bit frames (start, 8 data LSB-first, odd parity, stop). Delivers each good scan code as a 1-cycle pulse. Holds the last good code as two nibbles that drive the board's hex-to-7-segment display decoders directly downstream.

Parameters:
TIMEOUT_CYCLES, 50000, clk cycles without a ps2_clk falling edge mid-frame before the frame is abandoned (1 ms at 50 MHz); must be >= 2

Ports:
clk  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous reset, active-low
ps2_clk  input  1  raw PS/2 clock pin, asynchronous, idles high
ps2_data  input  1  raw PS/2 data pin, asynchronous, idles high
code  output  8  last good scan code
code_valid  output  1  1-cycle pulse: code just updated
frame_err  output  1  1-cycle pulse: parity/stop error or timeout
nib_hi  output  4  code[7:4], registered with code, feeds upper display digit
nib_lo  output  4  code[3:0], registered with code, feeds lower display digit
busy  output  1  high while a frame is in progress (state RECV)

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE, bit_cnt 0, shift reg 0, timeout counter 0; code/nib_hi/nib_lo 0; code_valid, frame_err, busy 0; synchronizer and previous-sample flops set to 1 (idle bus level).
- Reset mid-frame abandons the partial frame with no error pulse.
- Input conditioning: 2-flop synchronizer on each pin, plus one previous-sample flop on synced clk.
- fall = prev_clk & ~sync_clk, one cycle wide. Data is sampled from sync_data in the same cycle as fall.
- FSM states: IDLE, RECV.
  - IDLE: on fall with sync_data==0 (start bit), go to RECV with bit_cnt=1. On fall with sync_data==1, ignore and stay in IDLE.
  - RECV: each fall shifts sync_data in and increments bit_cnt. bit_cnt 1..8 are data (bit0 first), 9 is parity, 10 is stop.
  - On the fall for bit 10, always return to IDLE. Frame is good iff (^data ^ parity)==1 and stop==1.
  - Good frame: code, nib_hi, nib_lo updated and code_valid=1 on the same edge.
  - Bad frame: code and nibbles unchanged, frame_err=1.
- Timeout: counter clears on every fall and on entry to RECV, and increments each cycle in RECV. When it reaches TIMEOUT_CYCLES-1 with no fall, go to IDLE and pulse frame_err. A fall in that same cycle wins (no timeout).
- Latency: if ps2_clk is first sampled low for the stop bit at edge t0, code_valid/frame_err are high during the cycle after edge t0+2, for exactly one cycle.
- code_valid and frame_err are never high together. Both are 0 in all other cycles.
- busy = (state==RECV), registered.
- Throughput: back-to-back frames (e.g. 0xF0 then a break code) are received with no gap requirement beyond the PS/2 protocol itself.

Decomposition:
- Shared package ps2_pkg: state encoding (IDLE, RECV), FRAME_BITS=11, STOP_IDX=10, PARITY_IDX=9.
- One sub-module: ps2_sync_edge. It contains the 2-flop synchronizers for both lines and the falling-edge detector, with outputs sync_data and fall. Same clk/rst_n, reset values 1.
- Display decoders are instantiated outside this block, on nib_hi and nib_lo.

Test Plan:
- Frame 0x1C, parity 0, stop 1, PS/2 clock about 12 kHz -> one code_valid pulse 3 edges after the stop-bit low sample; code=0x1C, nib_hi=0x1, nib_lo=0xC; busy low afterwards.
- Frames 0xF0 (parity 1) then 0x1C back-to-back -> two code_valid pulses; final code=0x1C; frame_err never asserted.
- Frame 0x1C with parity 1 -> frame_err pulse, code stays at its prior value 0x45; stop bit 0 on 0x45 -> frame_err, code unchanged.
- TIMEOUT_CYCLES=100, clock stops after 5 bits -> frame_err exactly 99 cycles after the last fall, busy=0. Next frame 0x45 (parity 0) -> code_valid, code=0x45.
- Falling edge with data high while IDLE (spurious edge) -> no state change, no pulses; the following proper frame 0x1C is decoded correctly.
- rst_n low for 1 cycle after bit 6 of a frame -> all outputs 0, no frame_err; the next full frame 0x45 decodes to code=0x45.
